uart_tx: RTL
============

Name: uart_tx

Overview:
- UART transmit serializer that sits directly downstream of the UART TX FIFO.
- Pops one byte at a time from the FIFO read port and emits it on the serial line as an asynchronous frame: start bit, 8 data bits LSB first, optional parity, stop bit(s).
- Bit timing comes from an internal clock-cycle divider; no external baud tick.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit (>=2); 16 is sized for simulation.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- tx_en  input  1  allows new frames to start; sampled only in IDLE.
- fifo_empty  input  1  EMPTY flag from the TX FIFO.
- fifo_data  input  8  FIFO read data, valid the cycle after fifo_rd_en.
- fifo_rd_en  output  1  one-cycle FIFO read strobe (drives FIFO readEn).
- tx  output  1  serial line; idles high.
- busy  output  1  high in every state except IDLE.
- tx_done  output  1  one-cycle pulse at the end of the last stop bit.

Behaviour:
- Reset (async, any state):
  - state=IDLE; tx=1; fifo_rd_en=0; busy=0; tx_done=0.
  - Bit counter, divider and shift register all cleared.
  - Reset mid-frame aborts the frame immediately: tx goes high with no partial stop bit.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - If tx_en=1 and fifo_empty=0 at a rising edge, go to FETCH. Otherwise stay.
- FETCH:
  - Exactly one cycle; fifo_rd_en=1 only in this state (decoded from state, glitch-free).
  - FIFO updates fifo_data at the edge that ends FETCH.
  - Next state is LOAD.
- LOAD:
  - One cycle; fifo_data is captured into the shift register at the edge ending LOAD.
  - Parity is computed as XOR of the 8 bits, then XOR PARITY_ODD.
  - Next state is START.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA:
  - 8 bits, LSB first, each held CLKS_PER_BIT cycles.
  - Shift register shifts right at each bit boundary.
  - A 3-bit counter selects the last bit; counter wraps 7->0 on exit.
- PARITY:
  - Entered only if PARITY_EN=1, else skipped.
  - tx=parity bit for CLKS_PER_BIT cycles.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - tx_done=1 on the final cycle of STOP.
  - Next state is IDLE.
- Divider:
  - Counts 0..CLKS_PER_BIT-1 and reloads to 0 on every state entry.
  - The bit boundary is the cycle where count = CLKS_PER_BIT-1.
- Latency:
  - tx falls 2 cycles after the IDLE edge that accepts a request.
  - Frame length from that edge: 2 + (10 + PARITY_EN + STOP_BITS - 1) * CLKS_PER_BIT cycles.
- Back-to-back frames: return to IDLE costs 1 cycle, so the inter-frame line-high gap beyond the stop bit(s) is exactly 3 cycles (IDLE, FETCH, LOAD).
- tx_en deasserted mid-frame: the current frame completes and no new FETCH occurs.
- fifo_empty is ignored outside IDLE.
- At most one fifo_rd_en per frame. fifo_rd_en is never asserted while fifo_empty=1, which avoids FIFO underflow.
- tx is registered and glitch-free.

Test Plan:
- Basic frame: CLKS_PER_BIT=4, FIFO holds 0xA5, tx_en=1 -> one fifo_rd_en pulse; tx = 0 | 1,0,1,0,0,1,0,1 | 1, each bit 4 cycles; tx_done pulses once; busy high 2+40 cycles.
- Even/odd parity:
  - PARITY_EN=1, 0xA5 (four ones) -> parity bit 0.
  - PARITY_ODD=1 -> parity bit 1.
  - 0x6D -> even parity bit 1.
  - Frame is 11 bits + 2 overhead cycles.
- Empty FIFO / disabled:
  - fifo_empty=1 with tx_en=1 for 100 cycles -> fifo_rd_en never asserts, tx stays 1, busy=0.
  - Same for tx_en=0 with non-empty FIFO.
- Back-to-back: FIFO preloaded 0xFF, 0xA5, 0x6D -> exactly 3 rd_en pulses; frames decode in order; stop-bit-to-next-start gap exactly 3 high cycles; idle after FIFO drains.
- Reset mid-frame: assert reset during data bit 3 of 0xA5 -> tx=1 and busy=0 asynchronously; after release with FIFO empty, no further activity.
- tx_en drop: deassert tx_en during the START bit -> current byte fully transmitted, no further rd_en while tx_en=0; reassert -> next byte sent.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: FIFO-fed UART transmit serializer (start, 8 data LSB first, optional parity, stop bits).
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);
  localparam int DW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} state_t;
  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_q, par_d, stop_q, stop_d, tx_q, tx_d;
  logic          bit_end, last_stop;
  assign bit_end    = div_q == DW'(CLKS_PER_BIT - 1);
  assign last_stop  = stop_q == 1'(STOP_BITS - 1);
  assign fifo_rd_en = state_q == FETCH;
  assign busy       = state_q != IDLE;
  assign tx_done    = (state_q == STOP) && bit_end && last_stop;
  assign tx         = tx_q;
  // next-state logic; tx is derived from the next state so the line is registered and aligned with state_q
  always_comb begin
    state_d = state_q;
    div_d   = div_q + DW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    stop_d  = stop_q;
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (tx_en && !fifo_empty) state_d = FETCH;
      end
      FETCH: begin
        div_d   = '0;
        state_d = LOAD;
      end
      LOAD: begin
        div_d   = '0;
        sh_d    = fifo_data;
        par_d   = ^fifo_data ^ 1'(PARITY_ODD);
        state_d = START;
      end
      START: if (bit_end) begin
        div_d   = '0;
        state_d = DATA;
      end
      DATA: if (bit_end) begin
        div_d = '0;
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = (PARITY_EN != 0) ? PARITY : STOP;
        else sh_d = {1'b0, sh_q[7:1]};
      end
      PARITY: if (bit_end) begin
        div_d   = '0;
        state_d = STOP;
      end
      STOP: if (bit_end) begin
        div_d   = '0;
        stop_d  = !last_stop;
        state_d = last_stop ? IDLE : STOP;
      end
      default: state_d = IDLE;
    endcase
    tx_d = (state_d == START) ? 1'b0 :
           (state_d == DATA) ? sh_d[0] :
           (state_d == PARITY) ? par_d : 1'b1;
  end
  // state and datapath registers; reset aborts any frame and forces the line high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
    end
  end
endmodule
